// File: rtl/aes_pkg.sv
// AES byte-level shared types and the ShiftRows index map used by both the
// forward and inverse streaming blocks.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [7:0] aes_byte_t;
  typedef logic [3:0] aes_idx_t;

  // Source byte for output byte k (k = 4c+r). Row r rotates by r columns;
  // 2-bit column arithmetic gives the mod-4 wrap for free.
  function automatic aes_idx_t shiftrows_src(input aes_idx_t k, input logic inverse);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = k[1:0];
    c  = k[3:2];
    sc = inverse ? (c - r) : (c + r);
    return {sc, r};
  endfunction

endpackage

// File: rtl/aes_byte_bank.sv
// One 16x8 register bank with a single indexed write port and a single
// asynchronous indexed read port. Contents are never reset.
module aes_byte_bank
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      i_we,
  input  aes_idx_t  i_waddr,
  input  aes_byte_t i_wdata,
  input  aes_idx_t  i_raddr,
  output aes_byte_t o_rdata
);

  aes_byte_t r_mem [AES_BLOCK_BYTES];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inv_shiftrows_stream.sv
// Byte-serial AES InvShiftRows: bytes are written linearly into a ping-pong
// bank and read back through the inverse index map, one byte per cycle.
module inv_shiftrows_stream
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam aes_idx_t LAST_IDX = aes_idx_t'(AES_BLOCK_BYTES - 1);

  logic [1:0] r_full;
  logic       r_wb;
  logic       r_rb;
  aes_idx_t   r_in_cnt;
  aes_idx_t   r_out_cnt;

  logic       w_in_fire;
  logic       w_out_fire;
  logic [1:0] w_we;
  logic [1:0] w_set;
  logic [1:0] w_clr;
  aes_idx_t   w_raddr;
  aes_byte_t  w_rdata [2];

  assign w_in_fire  = in_valid && !r_full[r_wb];
  assign w_out_fire = r_full[r_rb] && out_ready;
  assign w_raddr    = shiftrows_src(r_out_cnt, 1'b1);

  // Fill and drain touch different banks, so set and clear never collide.
  always_comb begin
    w_we        = '0;
    w_set       = '0;
    w_clr       = '0;
    w_we[r_wb]  = w_in_fire;
    w_set[r_wb] = w_in_fire && (r_in_cnt == LAST_IDX);
    w_clr[r_rb] = w_out_fire && (r_out_cnt == LAST_IDX);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    aes_byte_bank u_bank (
      .clk     (clk),
      .i_we    (w_we[b]),
      .i_waddr (r_in_cnt),
      .i_wdata (in_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_full <= (r_full & ~w_clr) | w_set;
      if (w_in_fire) begin
        r_in_cnt <= r_in_cnt + 4'd1;
        if (r_in_cnt == LAST_IDX) r_wb <= ~r_wb;
      end
      if (w_out_fire) begin
        r_out_cnt <= r_out_cnt + 4'd1;
        if (r_out_cnt == LAST_IDX) r_rb <= ~r_rb;
      end
    end
  end

  assign in_ready  = !r_full[r_wb];
  assign out_valid = r_full[r_rb];
  assign out_data  = w_rdata[r_rb];
  assign out_last  = r_full[r_rb] && (r_out_cnt == LAST_IDX);
  assign busy      = (|r_full) || (r_in_cnt != '0);

endmodule

// File: tb/tb_inv_shiftrows_stream.sv
// Randomized bench for inv_shiftrows_stream against a block-level matrix model.
module tb_inv_shiftrows_stream;

  typedef logic [15:0][7:0] blk_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] in_buf[$];
  logic [7:0] exp_q[$];
  logic [7:0] rt_q[$];
  logic [7:0] out_log[$];
  logic       last_log[$];
  int         held = 0;
  int         out_idx = 0;
  int         n_outs = 0;
  bit         model_ok = 1'b0;
  bit         rt_mode = 1'b0;
  int         rmode = 0;

  int lit_tab[16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                      8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

  inv_shiftrows_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // State matrix s(r,c) = byte[4c+r]; forward rotates rows left, inverse right.
  function automatic blk_t shift_block(input blk_t s, input bit inverse);
    blk_t d;
    int   sc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = inverse ? (c - r + 4) % 4 : (c + r) % 4;
        d[4*c+r] = s[4*sc+r];
      end
    end
    return d;
  endfunction

  // Reference model and per-cycle compare, sampled on the falling edge.
  initial begin
    bit   e_ir, e_ov, e_busy, in_fire, out_fire;
    blk_t b, o;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_buf.delete();
        exp_q.delete();
        held     = 0;
        out_idx  = 0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        e_ir   = held < 2;
        e_ov   = held > 0;
        e_busy = (held > 0) || (in_buf.size() != 0);
        chk("in_ready", in_ready, e_ir);
        chk("out_valid", out_valid, e_ov);
        chk("busy", busy, e_busy);
        if (e_ov) begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_last", out_last, out_idx == 15);
        end else begin
          chk("out_last_idle", out_last, 0);
        end
        in_fire  = in_valid && e_ir;
        out_fire = e_ov && out_ready;
        if (out_fire) begin
          out_log.push_back(out_data);
          last_log.push_back(out_last);
          n_outs++;
          if (rt_mode) begin
            if (rt_q.size() == 0) chk("rt_underflow", 1, 0);
            else chk("roundtrip", out_data, rt_q.pop_front());
          end
          void'(exp_q.pop_front());
          out_idx++;
          if (out_idx == 16) begin
            out_idx = 0;
            held--;
          end
        end
        if (in_fire) begin
          in_buf.push_back(in_data);
          if (in_buf.size() == 16) begin
            for (int k = 0; k < 16; k++) b[k] = in_buf[k];
            o = shift_block(b, 1'b1);
            for (int k = 0; k < 16; k++) exp_q.push_back(o[k]);
            in_buf.delete();
            held++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 2000) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    in_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy && !out_valid) break;
      t++;
      if (t > 5000) begin
        chk("drain_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    blk_t a, f, g;
    int   t, sent;
    bit   seen;

    // Model pins: the inverse map of 00..0F and a forward/inverse round trip.
    for (int k = 0; k < 16; k++) a[k] = 8'(k);
    g = shift_block(a, 1'b1);
    for (int k = 0; k < 16; k++) chk("model_inv_lit", g[k], lit_tab[k]);
    f = shift_block(shift_block(a, 1'b0), 1'b1);
    chk("model_roundtrip", f, a);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // Known block 00..0F with latency check on the completing byte.
    rmode = 0;
    idle(1);
    out_log.delete();
    last_log.delete();
    for (int k = 0; k < 16; k++) send(8'(k));
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    wait_idle();
    chk("lit_count", out_log.size(), 16);
    if (out_log.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk("lit_data", out_log[k], lit_tab[k]);
        chk("lit_last", last_log[k], k == 15);
      end
    end

    // Three back-to-back blocks must stream 48 bytes without a gap.
    fork
      begin
        for (int k = 0; k < 48; k++) send(8'($urandom));
        in_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int w = 0; w < 100 && !seen; w++) begin
          @(negedge clk);
          seen = out_valid;
        end
        chk("nobubble_start", seen, 1);
        for (int i = 0; i < 48 && seen; i++) begin
          if (i > 0) @(negedge clk);
          chk("nobubble", out_valid, 1);
        end
      end
    join
    wait_idle();

    // Stall downstream while two blocks fill both banks.
    rmode = 2;
    idle(1);
    for (int k = 0; k < 32; k++) send(8'h20 + 8'(k));
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", out_data, 8'h20);
      chk("stall_last", out_last, 0);
    end
    @(posedge clk);
    #1;
    rmode = 0;
    wait_idle();
    chk("after_drain_in_ready", in_ready, 1);

    // Reset in the middle of a block discards the partial bytes.
    for (int k = 0; k < 7; k++) send(8'hA0 + 8'(k));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    n_outs = 0;
    for (int k = 0; k < 16; k++) send(8'($urandom));
    wait_idle();
    chk("midrst_out_count", n_outs, 16);

    // Round trip: forward ShiftRows in the bench, then the DUT.
    rt_mode = 1'b1;
    for (int blk = 0; blk < 500; blk++) begin
      for (int k = 0; k < 16; k++) a[k] = 8'($urandom);
      f = shift_block(a, 1'b0);
      for (int k = 0; k < 16; k++) rt_q.push_back(a[k]);
      for (int k = 0; k < 16; k++) send(f[k]);
    end
    wait_idle();
    rt_mode = 1'b0;
    chk("rt_leftover", rt_q.size(), 0);

    // Random handshakes on both sides.
    rmode  = 1;
    n_outs = 0;
    sent   = 0;
    for (int blk = 0; blk < 1000; blk++) begin
      for (int k = 0; k < 16; k++) begin
        t = 0;
        while (($urandom % 2) != 0 && t < 8) begin
          idle(1);
          t++;
        end
        send(8'($urandom));
        sent++;
      end
    end
    rmode = 0;
    wait_idle();
    chk("rand_count", n_outs, sent);
    chk("rand_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_shiftrows_stream.md
INV_SHIFTROWS_STREAM -- requirements
Module: inv_shiftrows_stream

Interface
REQ-001 The block SHALL have no parameters; block size is fixed at 16 bytes and lane width at 8 bits.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream byte on in_data is valid.
REQ-005 in_ready  output  1  block can accept a byte this cycle.
REQ-006 in_data  input  8  state byte; the stream order SHALL be k = 4c+r, with byte 0 = s(0,0), byte 1 = s(1,0), ... byte 15 = s(3,3).
REQ-007 out_valid  output  1  out_data holds a valid byte.
REQ-008 out_ready  input  1  downstream accepts the byte this cycle.
REQ-009 out_data  output  8  inverse-shifted state byte, same k order as the input.
REQ-010 out_last  output  1  high with out_valid on output byte k=15.
REQ-011 busy  output  1  high when any bank is full or a partial input block is held.

Function
REQ-012 The block SHALL implement InvShiftRows: out s(r,c) = in s(r,(c-r) mod 4).
REQ-013 Output byte k SHALL come from input byte src(k): 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3 for k=0..15.
REQ-014 Storage SHALL be two 16-byte banks (ping-pong) with write bank pointer wb, read bank pointer rb, per-bank full flags, a 4-bit in_cnt and a 4-bit out_cnt.
REQ-015 The block SHALL drive in_ready = !full[wb]; it SHALL be driven from registers only, with no combinational path from out_ready or in_valid.
REQ-016 On an input transfer (in_valid && in_ready), the block SHALL write in_data to bank[wb][in_cnt] and increment in_cnt; at in_cnt=15 it SHALL set full[wb], toggle wb and wrap in_cnt to 0.
REQ-017 The block SHALL drive out_valid = full[rb], out_data = bank[rb][src(out_cnt)], and out_last = full[rb] && out_cnt=15.
REQ-018 On an output transfer (out_valid && out_ready), the block SHALL increment out_cnt; at out_cnt=15 it SHALL clear full[rb], toggle rb and wrap out_cnt to 0.
REQ-019 While out_valid is high and out_ready is low, out_data and out_last SHALL hold stable.
REQ-020 Latency: if input byte 15 is accepted at edge N, out_valid SHALL be high in the cycle after edge N (zero added pipeline cycles).
REQ-021 With in_valid and out_ready held high, throughput SHALL be 1 byte/cycle in steady state, with no bubbles.
REQ-022 When one bank completes a fill while the other completes a drain in the same cycle, both flag updates SHALL take effect.
REQ-023 When both banks are full, in_ready SHALL be 0 until the read bank's byte 15 is transferred, then 1 in the following cycle.
REQ-024 Bytes presented while in_ready=0 SHALL NOT be written, and in_cnt SHALL NOT change.
REQ-025 busy SHALL be (full[0] || full[1] || in_cnt != 0).

Reset
REQ-026 While rst=1, in_cnt, out_cnt, wb, rb and both full flags SHALL be cleared on the next edge.
REQ-027 In the cycle after reset, outputs SHALL read: in_ready=1, out_valid=0, out_last=0, busy=0; out_data is don't-care while out_valid=0.
REQ-028 Bank contents SHALL NOT be reset.
REQ-029 rst asserted mid-block SHALL discard all partial and full blocks; the first accepted byte after reset SHALL be byte 0 of a new block.

Structure
REQ-030 Shared package aes_pkg SHALL hold AES_BLOCK_BYTES=16, the byte type, and the src(k) index function shared with the forward ShiftRows.
REQ-031 The bank SHALL be one sub-module, aes_byte_bank (16x8 registers, one indexed write port, one indexed read port), instantiated twice.

Verification
REQ-032 Input 00..0F with out_ready=1 -> output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03, with out_last on the 16th output byte.
REQ-033 Round trip: 500 random blocks through the forward ShiftRows then this block -> each output equals its original input.
REQ-034 Three back-to-back blocks with in_valid=1 and out_ready=1 -> 48 consecutive output bytes with no bubble after the first block.
REQ-035 out_ready=0 while two blocks are fed -> in_ready drops after byte 31, out_data stays stable; then out_ready=1 -> both blocks drain in order and in_ready rises.
REQ-036 rst pulse after 7 input bytes -> busy=0 and out_valid=0; a fresh 16-byte block then produces correct output with no residue.
REQ-037 Random in_valid/out_ready at 50% each over 1000 blocks -> scoreboard match, no loss and no duplication.
